mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage load/store unit between EX_MEM and MEM_WB. Takes the registered EX_MEM access, runs a req/ack
//  transaction on the data-memory bus, aligns and sign/zero-extends load data into ReadData for MEM_WB, and
//  stalls the pipeline (IF..EX_MEM frozen) while an access is in flight. Includes a bus timeout.
// PARAMETERS
//  XLEN            64   datapath/address width
//  TIMEOUT_CYCLES  255  max BUSY cycles without mem_ack before abort (>=1)
//  TO_W            8    timeout counter width, $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk                 in   1     clock, all state on rising edge
//  reset               in   1     asynchronous, active-low reset
//  EX_MEM_MemRead      in   1     load request
//  EX_MEM_MemWrite     in   1     store request
//  EX_MEM_Funct3       in   3     access size/sign (RV64 LB..LWU, SB..SD)
//  EX_MEM_ALU_Result   in   XLEN  effective byte address
//  EX_MEM_WriteData    in   XLEN  store data (rs2), low bytes significant
//  mem_req             out  1     bus request, held until ack
//  mem_we              out  1     1=write
//  mem_addr            out  XLEN  doubleword-aligned address (addr & ~7)
//  mem_wdata           out  XLEN  store data shifted into byte lane
//  mem_wstrb           out  8     byte strobes
//  mem_ack             in   1     bus completion; rdata valid same cycle
//  mem_rdata           in   XLEN  raw doubleword read data
//  ReadData            out  XLEN  aligned/extended load result to MEM_WB
//  mem_stall           out  1     freeze upstream pipeline and hold EX_MEM
//  bus_error           out  1     1-cycle pulse: access aborted by timeout
//  misaligned_fault    out  1     1-cycle pulse (MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, counter 0, every output 0; mem_stall forced 0 while reset low.
//  FSM IDLE/BUSY/DONE. access = MemRead|MemWrite; MemWrite wins if both set (store issued).
//  IDLE: access -> BUSY; register mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb; mem_stall=1 (comb).
//        no access -> stay; mem_stall=0; ReadData holds last value.
//  BUSY: mem_stall=1; counter++ each cycle. mem_ack=1 -> mem_req<=0, mem_we<=0, load: ReadData<=extend(shift
//        (mem_rdata, addr[2:0]*8)), -> DONE. Counter==TIMEOUT_CYCLES without ack -> mem_req<=0, ReadData<=0,
//        bus_error<=1, -> DONE. Ack and timeout same cycle: ack wins.
//  DONE: mem_stall=0 for exactly one cycle (MEM_WB samples ReadData this edge); bus_error/fault cleared next
//        edge; -> IDLE unconditionally (no re-issue of the same access). Counter cleared.
//  Latency: zero-wait memory (ack in first BUSY cycle) -> 2 stall cycles; each wait cycle adds 1.
//  Stores: ReadData unchanged. Funct3 sizes: 000/100 B, 001/101 H, 010/110 W, 011 D; 1xx loads zero-extend.
//  wstrb: B 0x01<<a, H 0x03<<a, W 0x0F<<a, D 0xFF (a=addr[2:0]); wdata = WriteData<<(a*8).
//  Undefined funct3 (111; store 1xx) treated as doubleword. mem_ack outside BUSY ignored.
//  Reset mid-BUSY: transaction abandoned, mem_req drops asynchronously; bus must tolerate it.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: addr not size-aligned -> no bus request; IDLE->DONE directly (1 stall cycle),
//    misaligned_fault=1 in DONE, ReadData<=0, no write.
//  Not defined: misaligned_fault tied 0; low address bits forced to size alignment (H:a&6, W:a&4, D:0).
// STRUCTURE
//  Package mem_stage_pkg: state enum (IDLE,BUSY,DONE), funct3 localparams, size-decode and strobe functions.
//  Sub-module load_align_ext: combinational lane shift + sign/zero extension (rdata, a, funct3 -> ReadData).
// TESTING
//  LD from 0x100, ack in first BUSY cycle, rdata=0x1122334455667788 -> ReadData=0x1122334455667788, stall 2 cycles.
//  LB addr 0x103, rdata byte3=0x80 -> ReadData=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
//  SH addr 0x106 data 0xBEEF, ack after 3 waits -> wstrb=0xC0, wdata=0xBEEF<<48, stall 5 cycles, ReadData held.
//  No ack, TIMEOUT_CYCLES=4 -> bus_error pulse in DONE, ReadData=0, mem_req low after 4 BUSY cycles.
//  Reset low mid-BUSY -> mem_req/mem_stall 0 immediately; after release, new LW issues cleanly.
//  MISALIGN_TRAP_EN, LW addr 0x102 -> no mem_req, misaligned_fault 1 cycle; without macro -> mem_addr 0x100.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_stage_pkg: FSM states, funct3 codes and access-size/strobe helpers for the MEM stage
package mem_stage_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;
   function automatic logic [1:0] size_of(input logic [2:0] f3, input logic st);
      return (f3 == F3_D || f3 == 3'b111 || (st && f3[2])) ? SZ_D :
             (f3 == F3_B || f3 == F3_BU) ? SZ_B :
             (f3 == F3_H || f3 == F3_HU) ? SZ_H :
             (f3 == F3_W || f3 == F3_WU) ? SZ_W : SZ_D;
   endfunction
   function automatic logic [2:0] align_mask(input logic [1:0] sz);
      return sz == SZ_B ? 3'b111 : sz == SZ_H ? 3'b110 : sz == SZ_W ? 3'b100 : 3'b000;
   endfunction
   function automatic logic [7:0] strobe(input logic [1:0] sz, input logic [2:0] a);
      return sz == SZ_B ? 8'h01 << a : sz == SZ_H ? 8'h03 << a : sz == SZ_W ? 8'h0F << a : 8'hFF;
   endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_bus_if: request/acknowledge data-memory bus between the MEM stage and memory
interface mem_bus_if #(parameter int XLEN = 64);
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wstrb;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_stage_align.sv
// load_align_ext: shifts the addressed byte lane of a doubleword down and sign/zero-extends it
module load_align_ext
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      a_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);
   logic [XLEN-1:0] sh;
   logic [1:0]      sz;
   logic            sg;
   // Bring the lane to bit 0, then extend according to size and signedness
   always_comb begin
      sh = rdata_i >> {a_i, 3'b000};
      sz = size_of(funct3_i, 1'b0);
      sg = funct3_i inside {F3_B, F3_H, F3_W};
      data_o = sz == SZ_B ? {{(XLEN-8){sg & sh[7]}}, sh[7:0]} :
               sz == SZ_H ? {{(XLEN-16){sg & sh[15]}}, sh[15:0]} :
               sz == SZ_W ? {{(XLEN-32){sg & sh[31]}}, sh[31:0]} : sh;
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit with bus timeout; MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            EX_MEM_MemRead,
   input  logic            EX_MEM_MemWrite,
   input  logic [2:0]      EX_MEM_Funct3,
   input  logic [XLEN-1:0] EX_MEM_ALU_Result,
   input  logic [XLEN-1:0] EX_MEM_WriteData,
   mem_bus_if.master       bus,
   output logic [XLEN-1:0] ReadData,
   output logic            mem_stall,
   output logic            bus_error,
   output logic            misaligned_fault
);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q;
   logic            req_q, we_q, ld_q, err_q, fault_q;
   logic [XLEN-1:0] addr_q, wdata_q, read_q, ld_data;
   logic [7:0]      wstrb_q;
   logic [2:0]      a_q, f3_q, a_raw, a_al;
   logic [1:0]      sz;
   logic            access, st, mis, to;
   assign access = EX_MEM_MemRead | EX_MEM_MemWrite;
   assign st     = EX_MEM_MemWrite;
   assign sz     = size_of(EX_MEM_Funct3, st);
   assign a_raw  = EX_MEM_ALU_Result[2:0];
   assign a_al   = a_raw & align_mask(sz);
   assign to     = cnt_q == TO_LAST;
`ifdef MISALIGN_TRAP_EN
   assign mis = a_al != a_raw;
`else
   assign mis = 1'b0;
`endif
   load_align_ext #(.XLEN(XLEN)) u_align (
      .rdata_i  (bus.mem_rdata),
      .a_i      (a_q),
      .funct3_i (f3_q),
      .data_o   (ld_data)
   );
   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   // Next state: issue or trap from IDLE, finish BUSY on ack or timeout, DONE always returns to IDLE
   always_comb begin
      state_d = state_q == IDLE ? (access ? (mis ? DONE : BUSY) : IDLE) :
                state_q == BUSY ? ((bus.mem_ack || to) ? DONE : BUSY) : IDLE;
   end
   // Stall upstream while an access is being issued or is in flight; released during reset
   always_comb begin
      mem_stall = reset && (state_q == BUSY || (state_q == IDLE && access));
   end
   // Bus request, captured access attributes, timeout counter and load result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         ld_q    <= 1'b0;
         err_q   <= 1'b0;
         fault_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         read_q  <= '0;
         a_q     <= '0;
         f3_q    <= '0;
      end else begin
         err_q   <= 1'b0;
         fault_q <= 1'b0;
         if (state_q == IDLE && access) begin
            if (mis) begin
               fault_q <= 1'b1;
               read_q  <= '0;
            end else begin
               req_q   <= 1'b1;
               we_q    <= st;
               addr_q  <= {EX_MEM_ALU_Result[XLEN-1:3], 3'b000};
               wdata_q <= EX_MEM_WriteData << {a_al, 3'b000};
               wstrb_q <= strobe(sz, a_al);
               a_q     <= a_al;
               f3_q    <= EX_MEM_Funct3;
               ld_q    <= !st;
            end
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + TO_W'(1);
            if (bus.mem_ack || to) begin
               req_q <= 1'b0;
               we_q  <= 1'b0;
            end
            if (bus.mem_ack && ld_q) read_q <= ld_data;
            else if (!bus.mem_ack && to) begin
               read_q <= '0;
               err_q  <= 1'b1;
            end
         end else if (state_q == DONE) cnt_q <= '0;
      end
   end
   assign bus.mem_req       = req_q;
   assign bus.mem_we        = we_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wstrb     = wstrb_q;
   assign ReadData          = read_q;
   assign bus_error         = err_q;
   assign misaligned_fault  = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random load/store checks against a byte-level memory model
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_rd, ex_wr;
   logic [2:0]  ex_f3;
   logic [63:0] ex_addr, ex_wd, read_data;
   logic        stall, berr, mfault;
   int          total = 0;
   int          bad = 0;
   logic [63:0] bmem [8];
   logic [7:0]  rmem [64];
   logic [63:0] exp_rd = '0;
   int          last_stalls;
   logic        last_seen, last_be, last_mf, last_we;
   logic [63:0] last_addr, last_wdata;
   logic [7:0]  last_wstrb;

   mem_bus_if #(.XLEN(64)) bus ();

   mem_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .EX_MEM_MemRead    (ex_rd),
      .EX_MEM_MemWrite   (ex_wr),
      .EX_MEM_Funct3     (ex_f3),
      .EX_MEM_ALU_Result (ex_addr),
      .EX_MEM_WriteData  (ex_wd),
      .bus               (bus),
      .ReadData          (read_data),
      .mem_stall         (stall),
      .bus_error         (berr),
      .misaligned_fault  (mfault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic wr, input logic [2:0] f3);
      return (f3 == 3'd7 || (wr && f3[2])) ? 8 : 1 << f3[1:0];
   endfunction

   task automatic poke(input int i, input logic [63:0] v);
      bmem[i] = v;
      for (int b = 0; b < 8; b++) rmem[i*8+b] = v[b*8 +: 8];
   endtask

   task automatic xfer(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input int waits);
      int n, off, busy, idx;
      logic trap, timed, done_ok;
      logic [63:0] ea, v;
      logic [7:0] es;
      n = nbytes(wr, f3);
      off = int'(addr[2:0]) % n;
      ea = addr - 64'(off);
`ifdef MISALIGN_TRAP_EN
      trap = off != 0;
`else
      trap = 1'b0;
`endif
      timed = !trap && waits >= 4;
      ex_rd = rd;
      ex_wr = wr;
      ex_f3 = f3;
      ex_addr = addr;
      ex_wd = wd;
      busy = 0;
      done_ok = 1'b0;
      last_seen = 1'b0;
      last_stalls = 0;
      #1;
      for (int c = 0; c < 40 && !done_ok; c++) begin
         bus.mem_ack = 1'b0;
         bus.mem_rdata = {$urandom, $urandom};
         if (!stall) done_ok = 1'b1;
         else begin
            last_stalls++;
            if (bus.mem_req) begin
               if (!last_seen) begin
                  last_seen = 1'b1;
                  last_addr = bus.mem_addr;
                  last_wdata = bus.mem_wdata;
                  last_wstrb = bus.mem_wstrb;
                  last_we = bus.mem_we;
               end
               busy++;
               if (busy == waits + 1) begin
                  bus.mem_ack = 1'b1;
                  idx = int'(bus.mem_addr[5:3]);
                  if (bus.mem_we)
                     for (int b = 0; b < 8; b++)
                        if (bus.mem_wstrb[b]) bmem[idx][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                  bus.mem_rdata = bmem[idx];
               end
            end
            @(negedge clk);
            #1;
         end
      end
      last_be = berr;
      last_mf = mfault;
      if (trap || timed) exp_rd = '0;
      else if (wr) for (int i = 0; i < n; i++) rmem[int'(ea - 64'h100) + i] = wd[8*i +: 8];
      else begin
         v = '0;
         for (int i = 0; i < n; i++) v |= 64'(rmem[int'(ea - 64'h100) + i]) << (8*i);
         if (!f3[2] && n < 8 && v[8*n-1]) v |= ~64'h0 << (8*n);
         exp_rd = v;
      end
      chk("done_reached", done_ok, 1);
      chk("stall_cycles", last_stalls, trap ? 1 : timed ? 5 : 2 + waits);
      chk("read_data", read_data, exp_rd);
      chk("bus_error", berr, timed);
      chk("misaligned_fault", mfault, trap);
      chk("req_in_done", bus.mem_req, 0);
      chk("req_issued", last_seen, !trap);
      if (last_seen) begin
         chk("mem_addr", last_addr, ea & ~64'h7);
         chk("mem_we", last_we, wr);
         if (wr) begin
            es = 8'((1 << n) - 1) << ea[2:0];
            chk("mem_wstrb", last_wstrb, es);
            chk("mem_wdata", last_wdata, wd << (8*ea[2:0]));
         end
      end
      ex_rd = 1'b0;
      ex_wr = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("error_cleared", berr, 0);
      chk("fault_cleared", mfault, 0);
      chk("idle_no_stall", stall, 0);
      chk("read_data_held", read_data, exp_rd);
   endtask

   initial begin
      logic [63:0] v;
      logic rd, wr;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      ex_rd = 1'b1;
      ex_wr = 1'b0;
      ex_f3 = 3'b011;
      ex_addr = 64'h100;
      ex_wd = '0;
      for (int i = 0; i < 8; i++) poke(i, {$urandom, $urandom});
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", bus.mem_req, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_wstrb", bus.mem_wstrb, 0);
      chk("rst_stall", stall, 0);
      chk("rst_read_data", read_data, 0);
      chk("rst_bus_error", berr, 0);
      chk("rst_fault", mfault, 0);
      ex_rd = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      poke(0, 64'h1122334455667788);
      xfer(1'b1, 1'b0, 3'b011, 64'h100, '0, 0);
      chk("ld_value", read_data, 64'h1122334455667788);
      chk("ld_stalls", last_stalls, 2);

      poke(0, 64'h0000000080000000);
      xfer(1'b1, 1'b0, 3'b000, 64'h103, '0, 1);
      chk("lb_value", read_data, 64'hFFFFFFFFFFFFFF80);
      xfer(1'b1, 1'b0, 3'b100, 64'h103, '0, 0);
      chk("lbu_value", read_data, 64'h80);

      xfer(1'b0, 1'b1, 3'b001, 64'h106, 64'hBEEF, 3);
      chk("sh_wstrb", last_wstrb, 8'hC0);
      chk("sh_wdata", last_wdata, 64'hBEEF000000000000);
      chk("sh_stalls", last_stalls, 5);
      chk("sh_read_held", read_data, 64'h80);

      xfer(1'b1, 1'b0, 3'b011, 64'h110, '0, 20);
      chk("to_bus_error", last_be, 1);
      chk("to_read_zero", read_data, 0);

      ex_rd = 1'b1;
      ex_wr = 1'b0;
      ex_f3 = 3'b010;
      ex_addr = 64'h108;
      @(negedge clk);
      #1;
      chk("busy_req", bus.mem_req, 1);
      #1 reset = 1'b0;
      #1;
      chk("midrst_req", bus.mem_req, 0);
      chk("midrst_stall", stall, 0);
      chk("midrst_read_data", read_data, 0);
      exp_rd = '0;
      @(negedge clk);
      reset = 1'b1;
      xfer(1'b1, 1'b0, 3'b010, 64'h108, '0, 1);

      poke(0, 64'hCAFEBABEDEADBEEF);
      xfer(1'b1, 1'b0, 3'b010, 64'h102, '0, 0);
`ifdef MISALIGN_TRAP_EN
      chk("lw_mis_fault", last_mf, 1);
      chk("lw_mis_noreq", last_seen, 0);
`else
      chk("lw_mis_addr", last_addr, 64'h100);
      chk("lw_mis_value", read_data, 64'hFFFFFFFFDEADBEEF);
`endif

      for (int k = 0; k < 40; k++) begin
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         xfer(rd, wr, 3'($urandom_range(0, 7)), 64'h100 + 64'($urandom_range(0, 63)),
              {$urandom, $urandom}, $urandom_range(0, 5));
      end

      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < 8; b++) v[b*8 +: 8] = rmem[i*8+b];
         chk("mem_image", bmem[i], v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
